packet_receiver: RTL and testbench
==================================

PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have parameter flit_size, default 4, bits per flit.
REQ-002 SHALL have parameter packet_size, default 32, bits per packet; address_flit_number = address_size/flit_size, flit_number = packet_size/flit_size.
REQ-003 SHALL have parameter address_size, default 16, destination address bits, first on the link.
REQ-004 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have flit_in  input  flit_size  flit from upstream port controller.
REQ-007 SHALL have flit_valid  input  1  flit_in is valid this cycle.
REQ-008 SHALL have receiver_full  output  1  backpressure to upstream (drives its destination_full).
REQ-009 SHALL have local_address  input  address_size  this node's address (used only with ADDR_MATCH_EN).
REQ-010 SHALL have packet_out  output  packet_size  assembled packet {address, payload}.
REQ-011 SHALL have packet_address  output  address_size  packet_out[packet_size-1 -: address_size].
REQ-012 SHALL have packet_valid  output  1  packet_out complete and held.
REQ-013 SHALL have packet_ack  input  1  consumer takes packet_out.
REQ-014 SHALL have packet_dropped  output  1  one-cycle pulse, packet discarded on address mismatch.

Function
REQ-015 Flit SHALL be accepted in a cycle iff flit_valid=1 and receiver_full=0; no other cycle changes the shift register or flit counter.
REQ-016 Accepted flit SHALL shift in at LSB end (shift left by flit_size); first flit ends in MSB flit position.
REQ-017 States SHALL be IDLE, RECV_ADDR, RECV_PAYLOAD, HOLD, DROP.
REQ-018 IDLE: counter=0; accepted flit -> RECV_ADDR with counter=1 (RECV_PAYLOAD if address_flit_number=1).
REQ-019 RECV_ADDR: each accept increments counter; accept with counter=address_flit_number-1 -> RECV_PAYLOAD (or DROP per REQ-029).
REQ-020 RECV_PAYLOAD: accept with counter=flit_number-1 -> HOLD, counter cleared.
REQ-021 HOLD: packet_valid=1, receiver_full=1; packet_ack=1 -> IDLE next cycle; packet_out stable while in HOLD.
REQ-022 receiver_full SHALL be 1 only in HOLD, decoded combinationally from state.
REQ-023 Latency: packet_valid SHALL rise the cycle after the last flit is accepted.
REQ-024 Gaps (flit_valid=0) in any receive state SHALL hold state, counter, shift register.
REQ-025 packet_ack outside HOLD SHALL be ignored.
REQ-026 Counter width SHALL be $clog2(flit_number)+1; never wraps within a packet.
REQ-027 Back-to-back: first flit of next packet SHALL be accepted no earlier than the cycle after ack (one-cycle bubble minimum).

Reset
REQ-028 reset=0 SHALL immediately force IDLE, counter=0, shift register=0, packet_valid=0, receiver_full=0, packet_dropped=0; partial or held packet discarded, also mid-packet.

Configuration
REQ-029 With ADDR_MATCH_EN defined: at completion of address (REQ-019), if assembled address != local_address -> DROP; DROP accepts remaining payload flits (receiver_full=0), counter as in RECV_PAYLOAD, never asserts packet_valid, pulses packet_dropped in cycle after last flit accepted, then IDLE.
REQ-030 Without ADDR_MATCH_EN: no DROP state, local_address ignored, packet_dropped tied 0, every packet reaches HOLD.

Structure
REQ-031 State encoding and derived flit-count localparams SHALL live in shared package noc_pkg, also used by port_controller.
REQ-032 Shift register with load enable SHALL be sub-module flit_shift_reg (params flit_size, packet_size); FSM and counter remain in packet_receiver.

Verification
REQ-033 Flits 1,2,3,4,A,B,C,D valid on 8 consecutive cycles -> packet_valid next cycle, packet_out=32'h1234ABCD, packet_address=16'h1234.
REQ-034 Same packet with flit_valid=0 for 3 cycles after 2nd and 6th flit -> identical packet_out, packet_valid 1 cycle after 8th accept.
REQ-035 Packet in HOLD, ack withheld 5 cycles while upstream presents flit 5 -> receiver_full=1, no accept, packet_out unchanged; ack -> IDLE, flit 5 accepted next cycle.
REQ-036 Reset=0 after 3 flits, release, send full packet 8'h… 8,7,6,5,4,3,2,1 -> packet_out=32'h87654321 (no residue).
REQ-037 ADDR_MATCH_EN, local_address=16'h1234, address 16'h1235 + 4 payload flits -> no packet_valid, packet_dropped one pulse, IDLE; then matching packet -> packet_valid.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the NoC link blocks (packet_receiver,
// port_controller).
//   - Default link geometry: flit, packet and address widths in bits.
//   - flit_count(): number of flits needed to carry a field of a given width.
//   - rx_state_t: receive FSM state encoding.
package noc_pkg;

   localparam int FLIT_SIZE    = 4;
   localparam int PACKET_SIZE  = 32;
   localparam int ADDRESS_SIZE = 16;

   // Flits needed to carry 'bits' on a link that is 'fsize' bits wide.
   function automatic int flit_count(input int bits, input int fsize);
      return bits / fsize;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_RECV_ADDR    = 3'd1,
      ST_RECV_PAYLOAD = 3'd2,
      ST_HOLD         = 3'd3,
      ST_DROP         = 3'd4
   } rx_state_t;

endpackage

// File: rtl/flit_shift_reg.sv
// flit_shift_reg: packet assembly shift register.
// Each loaded flit enters at the LSB end, and the contents move up by one
// flit, so the first flit of a packet finishes in the MSB flit position.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset, clears the register
//   load    in   shift flit_in in this cycle
//   flit_in in   incoming flit
//   data_q  out  register contents
module flit_shift_reg #(
   parameter int flit_size   = 4,
   parameter int packet_size = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [flit_size-1:0]   flit_in,
   output logic [packet_size-1:0] data_q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= {data_q[packet_size-flit_size-1:0], flit_in};
      end
   end

endmodule

// File: rtl/packet_receiver.sv
// packet_receiver: collects flits from an upstream port controller into a
// packet {address, payload}. It holds the complete packet until the consumer
// acknowledges it.
// Optional feature: define ADDR_MATCH_EN to discard packets whose address
// differs from local_address. Without it, every packet is delivered.
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   flit_in        in   flit from upstream
//   flit_valid     in   flit_in valid this cycle
//   receiver_full  out  backpressure to upstream (high only while holding)
//   local_address  in   this node's address (ADDR_MATCH_EN only)
//   packet_out     out  assembled packet
//   packet_address out  address field of packet_out
//   packet_valid   out  packet_out complete and held
//   packet_ack     in   consumer takes packet_out
//   packet_dropped out  one-cycle pulse when a packet is discarded
//   state_dbg      out  current FSM state (rx_state_t encoding)
module packet_receiver
   import noc_pkg::*;
#(
   parameter int flit_size    = FLIT_SIZE,
   parameter int packet_size  = PACKET_SIZE,
   parameter int address_size = ADDRESS_SIZE
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [flit_size-1:0]    flit_in,
   input  logic                    flit_valid,
   output logic                    receiver_full,
   input  logic [address_size-1:0] local_address,
   output logic [packet_size-1:0]  packet_out,
   output logic [address_size-1:0] packet_address,
   output logic                    packet_valid,
   input  logic                    packet_ack,
   output logic                    packet_dropped,
   output logic [2:0]              state_dbg
);

   localparam int address_flit_number = flit_count(address_size, flit_size);
   localparam int flit_number         = flit_count(packet_size, flit_size);
   localparam int cnt_w               = $clog2(flit_number) + 1;
   localparam logic [cnt_w-1:0] addr_last = cnt_w'(address_flit_number - 1);
   localparam logic [cnt_w-1:0] pkt_last  = cnt_w'(flit_number - 1);

   // Handshakes:
   // - Upstream: a flit transfers in a cycle where flit_valid=1 and
   //   receiver_full=0. A flit presented while receiver_full=1 is not taken
   //   and must be held by the sender.
   // - Downstream: packet_valid stays high and packet_out stays stable until
   //   the cycle with packet_ack=1. packet_ack is ignored at other times.
   rx_state_t        state_q, state_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             addr_ok;     // the address just completed is ours
   logic             drop_done;   // last flit of a discarded packet accepted

   assign receiver_full  = (state_q == ST_HOLD);
   assign packet_valid   = (state_q == ST_HOLD);
   assign accept         = flit_valid && !receiver_full;
   assign state_dbg      = state_q;
   assign packet_address = packet_out[packet_size-1 -: address_size];

   flit_shift_reg #(
      .flit_size   (flit_size),
      .packet_size (packet_size)
   ) u_shift (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .flit_in (flit_in),
      .data_q  (packet_out)
   );

`ifdef ADDR_MATCH_EN
   // The address is judged in the same cycle its last flit arrives. It is
   // taken from the value the shift register is about to load.
   logic [packet_size+flit_size-1:0] shift_next;
   logic                             unused_shift_hi;
   logic                             dropped_q;

   assign shift_next      = {packet_out, flit_in};
   assign addr_ok         = (shift_next[address_size-1:0] == local_address);
   assign unused_shift_hi = ^shift_next[packet_size+flit_size-1:address_size];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dropped_q <= 1'b0;
      end else begin
         dropped_q <= drop_done;
      end
   end

   assign packet_dropped = dropped_q;
`else
   logic unused_inputs;

   assign addr_ok        = 1'b1;
   assign packet_dropped = 1'b0;
   assign unused_inputs  = ^{local_address, drop_done};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      drop_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d = cnt_w'(1);
               if (address_flit_number == 1) begin
                  state_d = addr_ok ? ST_RECV_PAYLOAD : ST_DROP;
               end else begin
                  state_d = ST_RECV_ADDR;
               end
            end
         end
         ST_RECV_ADDR: begin
            if (accept) begin
               cnt_d = cnt_q + cnt_w'(1);
               if (cnt_q == addr_last) begin
                  state_d = addr_ok ? ST_RECV_PAYLOAD : ST_DROP;
               end
            end
         end
         // DROP counts exactly like RECV_PAYLOAD. The difference is the exit:
         // a dropped packet goes back to IDLE instead of to HOLD.
         ST_RECV_PAYLOAD, ST_DROP: begin
            if (accept) begin
               if (cnt_q == pkt_last) begin
                  cnt_d = '0;
                  if (state_q == ST_DROP) begin
                     state_d   = ST_IDLE;
                     drop_done = 1'b1;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + cnt_w'(1);
               end
            end
         end
         ST_HOLD: begin
            if (packet_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: directed tests for packet_receiver.
// Scenarios: reset values, a back-to-back packet, a packet with idle gaps,
// backpressure in HOLD, reset in the middle of a packet, packet_ack outside
// HOLD, and address filtering (ADDR_MATCH_EN) or its absence.
`timescale 1ns/1ps
module tb_packet_receiver;
   import noc_pkg::*;

   logic        clk;
   logic        reset;
   logic [3:0]  flit_in;
   logic        flit_valid;
   logic        receiver_full;
   logic [15:0] local_address;
   logic [31:0] packet_out;
   logic [15:0] packet_address;
   logic        packet_valid;
   logic        packet_ack;
   logic        packet_dropped;
   logic [2:0]  state_dbg;

   int tests_run    = 0;
   int tests_failed = 0;

   packet_receiver #(
      .flit_size    (4),
      .packet_size  (32),
      .address_size (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flit_in        (flit_in),
      .flit_valid     (flit_valid),
      .receiver_full  (receiver_full),
      .local_address  (local_address),
      .packet_out     (packet_out),
      .packet_address (packet_address),
      .packet_valid   (packet_valid),
      .packet_ack     (packet_ack),
      .packet_dropped (packet_dropped),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   // Present one flit for one cycle. Outputs are sampled 1ns after the edge.
   task automatic send_flit(input logic [3:0] f);
      flit_in    = f;
      flit_valid = 1'b1;
      @(posedge clk);
      #1;
      flit_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_packet(input logic [31:0] p);
      for (int i = 7; i >= 0; i--) begin
         send_flit(p[i*4 +: 4]);
      end
   endtask

   task automatic do_ack();
      packet_ack = 1'b1;
      @(posedge clk);
      #1;
      packet_ack = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      idle_cycles(2);
      tests_run++;
      if (state_dbg !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
      end
      tests_run++;
      if (packet_out !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_packet_out: got %h expected 00000000", packet_out);
      end
      tests_run++;
      if ({packet_valid, receiver_full, packet_dropped} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 000",
                  {packet_valid, receiver_full, packet_dropped});
      end
      reset = 1'b1;
      idle_cycles(1);
   endtask

   task automatic test_basic();
      send_packet(32'h1234ABCD);
      tests_run++;
      if (packet_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_valid: got %b expected 1", packet_valid);
      end
      tests_run++;
      if (packet_out !== 32'h1234ABCD) begin
         tests_failed++;
         $display("FAIL basic_packet_out: got %h expected 1234abcd", packet_out);
      end
      tests_run++;
      if (packet_address !== 16'h1234) begin
         tests_failed++;
         $display("FAIL basic_address: got %h expected 1234", packet_address);
      end
      tests_run++;
      if (receiver_full !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_full: got %b expected 1", receiver_full);
      end
      do_ack();
      tests_run++;
      if (state_dbg !== ST_IDLE || packet_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_after_ack: got state %0d valid %b expected state 0 valid 0",
                  state_dbg, packet_valid);
      end
   endtask

   // Gaps after flits 2 and 6. The packet is left in HOLD for the next test.
   task automatic test_gaps();
      logic [31:0] p;
      p = 32'h1234ABCD;
      for (int i = 7; i >= 0; i--) begin
         send_flit(p[i*4 +: 4]);
         if (i == 6) begin
            idle_cycles(3);
            tests_run++;
            if (state_dbg !== ST_RECV_ADDR || packet_out[7:0] !== 8'h12) begin
               tests_failed++;
               $display("FAIL gaps_hold_addr: got state %0d low %h expected state 1 low 12",
                        state_dbg, packet_out[7:0]);
            end
         end
         if (i == 2) begin
            idle_cycles(3);
            tests_run++;
            if (state_dbg !== ST_RECV_PAYLOAD || packet_out[23:0] !== 24'h1234AB) begin
               tests_failed++;
               $display("FAIL gaps_hold_payload: got state %0d low %h expected state 2 low 1234ab",
                        state_dbg, packet_out[23:0]);
            end
         end
         if (i == 1) begin
            tests_run++;
            if (packet_valid !== 1'b0) begin
               tests_failed++;
               $display("FAIL gaps_early_valid: got %b expected 0", packet_valid);
            end
         end
      end
      tests_run++;
      if (packet_valid !== 1'b1 || packet_out !== 32'h1234ABCD) begin
         tests_failed++;
         $display("FAIL gaps_packet: got valid %b out %h expected valid 1 out 1234abcd",
                  packet_valid, packet_out);
      end
   endtask

   // The packet from test_gaps is in HOLD. Upstream presents flit 5.
   task automatic test_hold_backpressure();
      flit_in    = 4'h5;
      flit_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if (receiver_full !== 1'b1 || state_dbg !== ST_HOLD || packet_out !== 32'h1234ABCD) begin
            tests_failed++;
            $display("FAIL hold_backpressure: cycle %0d got full %b state %0d out %h expected 1 3 1234abcd",
                     c, receiver_full, state_dbg, packet_out);
         end
      end
      packet_ack = 1'b1;
      @(posedge clk);
      #1;
      packet_ack = 1'b0;
      tests_run++;
      if (state_dbg !== ST_IDLE || receiver_full !== 1'b0 || packet_out !== 32'h1234ABCD) begin
         tests_failed++;
         $display("FAIL hold_ack_bubble: got state %0d full %b out %h expected 0 0 1234abcd",
                  state_dbg, receiver_full, packet_out);
      end
      @(posedge clk);
      #1;
      flit_valid = 1'b0;
      tests_run++;
      if (state_dbg !== ST_RECV_ADDR || packet_out !== 32'h234ABCD5) begin
         tests_failed++;
         $display("FAIL hold_next_accept: got state %0d out %h expected 1 234abcd5",
                  state_dbg, packet_out);
      end
   endtask

   // One flit (5) is already in. Two more arrive, then reset is asserted
   // between clock edges.
   task automatic test_reset_mid_packet();
      send_flit(4'h6);
      send_flit(4'h7);
      #3;
      reset = 1'b0;
      #1;
      tests_run++;
      if (state_dbg !== ST_IDLE || packet_out !== 32'h0 || receiver_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_async: got state %0d out %h full %b expected 0 0 0",
                  state_dbg, packet_out, receiver_full);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle_cycles(1);
      send_packet(32'h87654321);
      tests_run++;
      if (packet_valid !== 1'b1 || packet_out !== 32'h87654321 || packet_address !== 16'h8765) begin
         tests_failed++;
         $display("FAIL midreset_packet: got valid %b out %h addr %h expected 1 87654321 8765",
                  packet_valid, packet_out, packet_address);
      end
      do_ack();
   endtask

   task automatic test_ack_outside_hold();
      logic [31:0] p;
      p = 32'hC35A0F96;
      send_flit(p[31:28]);
      send_flit(p[27:24]);
      packet_ack = 1'b1;
      idle_cycles(2);
      packet_ack = 1'b0;
      tests_run++;
      if (state_dbg !== ST_RECV_ADDR || packet_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL stray_ack: got state %0d valid %b expected 1 0", state_dbg, packet_valid);
      end
      for (int i = 5; i >= 0; i--) begin
         send_flit(p[i*4 +: 4]);
      end
      tests_run++;
      if (packet_valid !== 1'b1 || packet_out !== 32'hC35A0F96) begin
         tests_failed++;
         $display("FAIL stray_ack_packet: got valid %b out %h expected 1 c35a0f96",
                  packet_valid, packet_out);
      end
      do_ack();
   endtask

   task automatic test_address_filter();
      local_address = 16'h1234;
`ifdef ADDR_MATCH_EN
      send_flit(4'h1);
      send_flit(4'h2);
      send_flit(4'h3);
      send_flit(4'h5);
      tests_run++;
      if (state_dbg !== ST_DROP || receiver_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL drop_enter: got state %0d full %b expected 4 0", state_dbg, receiver_full);
      end
      send_flit(4'hE);
      send_flit(4'hE);
      send_flit(4'hE);
      tests_run++;
      if (packet_dropped !== 1'b0 || state_dbg !== ST_DROP) begin
         tests_failed++;
         $display("FAIL drop_early: got dropped %b state %0d expected 0 4", packet_dropped, state_dbg);
      end
      send_flit(4'hE);
      tests_run++;
      if (packet_dropped !== 1'b1 || state_dbg !== ST_IDLE || packet_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL drop_pulse: got dropped %b state %0d valid %b expected 1 0 0",
                  packet_dropped, state_dbg, packet_valid);
      end
      idle_cycles(1);
      tests_run++;
      if (packet_dropped !== 1'b0) begin
         tests_failed++;
         $display("FAIL drop_pulse_width: got %b expected 0", packet_dropped);
      end
      send_packet(32'h1234ABCD);
      tests_run++;
      if (packet_valid !== 1'b1 || packet_out !== 32'h1234ABCD) begin
         tests_failed++;
         $display("FAIL match_after_drop: got valid %b out %h expected 1 1234abcd",
                  packet_valid, packet_out);
      end
      do_ack();
`else
      send_packet(32'h123500FF);
      tests_run++;
      if (packet_valid !== 1'b1 || packet_out !== 32'h123500FF || packet_dropped !== 1'b0) begin
         tests_failed++;
         $display("FAIL no_filter: got valid %b out %h dropped %b expected 1 123500ff 0",
                  packet_valid, packet_out, packet_dropped);
      end
      do_ack();
`endif
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      flit_in       = 4'h0;
      flit_valid    = 1'b0;
      packet_ack    = 1'b0;
      local_address = 16'h1234;
      reset         = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_hold_backpressure();
      test_reset_mid_packet();
      test_ack_outside_hold();
      test_address_filter();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
